// File: rtl/ccd_window_capture.sv
// Raw Bayer capture stage: start/stop gating, windowed crop with optional 2x2
// Bayer-preserving decimation, frame counting and raw line/frame geometry.
module ccd_window_capture #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FRAME_W = 32
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic               iSTART,
  input  logic               iEND,
  input  logic [CNT_W-1:0]   iWIN_X0,
  input  logic [CNT_W-1:0]   iWIN_Y0,
  input  logic [CNT_W-1:0]   iWIN_W,
  input  logic [CNT_W-1:0]   iWIN_H,
  input  logic               iDECIM,
  input  logic               iCLR_ERR,
  output logic [DATA_W-1:0]  oDATA,
  output logic               oDVAL,
  output logic [CNT_W-1:0]   oX_Cont,
  output logic [CNT_W-1:0]   oY_Cont,
  output logic [FRAME_W-1:0] oFrame_Cont,
  output logic               oRUN,
  output logic [CNT_W-1:0]   oLINE_LEN,
  output logic [CNT_W-1:0]   oFRAME_LINES,
  output logic               oLEN_ERR
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]  data_d1_q;
  logic               fval_d1_q, lval_d1_q, fval_d2_q, lval_d2_q;
  logic               run_q, run_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]   win_x0_q, win_x0_d, win_y0_q, win_y0_d;
  logic [CNT_W-1:0]   win_w_q, win_w_d, win_h_q, win_h_d;
  logic               decim_q, decim_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dval_q, dval_d;
  logic [CNT_W-1:0]   xo_q, xo_d, yo_q, yo_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic               err_q, err_d;

  logic               fval_rise, fval_fall, lval_fall, enter, capture, keep;
  logic               in_x, in_y, decim_e;
  logic [CNT_W-1:0]   x0_e, y0_e, w_e, h_e, y_cur, dx, dy, x_comp, y_comp;

  assign fval_rise = fval_d1_q & ~fval_d2_q;
  assign fval_fall = ~fval_d1_q & fval_d2_q;
  assign lval_fall = ~lval_d1_q & lval_d2_q;

  // On the entry cycle the shadows are not loaded yet, so use the live inputs.
  assign enter   = (state_q == WAIT_FRAME) & run_q & fval_rise;
  assign capture = (state_q == ACTIVE) | enter;
  assign x0_e    = enter ? iWIN_X0 : win_x0_q;
  assign y0_e    = enter ? iWIN_Y0 : win_y0_q;
  assign w_e     = enter ? iWIN_W  : win_w_q;
  assign h_e     = enter ? iWIN_H  : win_h_q;
  assign decim_e = enter ? iDECIM  : decim_q;
  assign y_cur   = fval_rise ? '0 : y_q;

  // Window bounds compared one bit wider so X0+W cannot overflow.
  assign in_x = ({1'b0, x_q} >= {1'b0, x0_e}) &&
                ({1'b0, x_q} < ({1'b0, x0_e} + {1'b0, w_e}));
  assign in_y = ({1'b0, y_cur} >= {1'b0, y0_e}) &&
                ({1'b0, y_cur} < ({1'b0, y0_e} + {1'b0, h_e}));

  assign dx     = x_q - x0_e;
  assign dy     = y_cur - y0_e;
  assign x_comp = decim_e ? CNT_W'({dx[CNT_W-1:2], dx[0]}) : dx;
  assign y_comp = decim_e ? CNT_W'({dy[CNT_W-1:2], dy[0]}) : dy;
  assign keep   = capture & lval_d1_q & in_x & in_y &
                  (~decim_e | (~dx[1] & ~dy[1]));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (run_q) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!run_q)         state_d = IDLE;
        else if (fval_rise) state_d = ACTIVE;
      end
      ACTIVE:     if (fval_fall) state_d = run_q ? WAIT_FRAME : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    run_d         = iEND ? 1'b0 : (iSTART ? 1'b1 : run_q);
    x_d           = x_q;
    y_d           = y_q;
    win_x0_d      = win_x0_q;
    win_y0_d      = win_y0_q;
    win_w_d       = win_w_q;
    win_h_d       = win_h_q;
    decim_d       = decim_q;
    data_d        = data_q;
    dval_d        = keep;
    xo_d          = xo_q;
    yo_d          = yo_q;
    frame_d       = frame_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    err_d         = err_q;

    if (lval_fall) begin
      x_d = '0;
    end else if (fval_d1_q & lval_d1_q & (x_q != '1)) begin
      x_d = x_q + CNT_W'(1);
    end

    if (fval_rise) begin
      y_d = '0;
    end else if (lval_fall & (fval_d1_q | fval_d2_q) & (y_q != '1)) begin
      y_d = y_q + CNT_W'(1);
    end

    if (enter) begin
      win_x0_d = iWIN_X0;
      win_y0_d = iWIN_Y0;
      win_w_d  = iWIN_W;
      win_h_d  = iWIN_H;
      decim_d  = iDECIM;
    end

    if (keep) begin
      data_d = data_d1_q;
      xo_d   = x_comp;
      yo_d   = y_comp;
    end

    if (iCLR_ERR) err_d = 1'b0;
    // First line of a frame has no predecessor to compare against.
    if ((state_q == ACTIVE) && lval_fall) begin
      line_len_d = x_q;
      if ((y_q != '0) && (x_q != line_len_q)) err_d = 1'b1;
    end

    if ((state_q == ACTIVE) && fval_fall) begin
      frame_d       = frame_q + FRAME_W'(1);
      frame_lines_d = y_d;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      data_d1_q     <= '0;
      fval_d1_q     <= 1'b0;
      lval_d1_q     <= 1'b0;
      fval_d2_q     <= 1'b0;
      lval_d2_q     <= 1'b0;
      run_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      win_x0_q      <= '0;
      win_y0_q      <= '0;
      win_w_q       <= '0;
      win_h_q       <= '0;
      decim_q       <= 1'b0;
      data_q        <= '0;
      dval_q        <= 1'b0;
      xo_q          <= '0;
      yo_q          <= '0;
      frame_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= 1'b0;
    end else begin
      data_d1_q     <= iDATA;
      fval_d1_q     <= iFVAL;
      lval_d1_q     <= iLVAL;
      fval_d2_q     <= fval_d1_q;
      lval_d2_q     <= lval_d1_q;
      run_q         <= run_d;
      x_q           <= x_d;
      y_q           <= y_d;
      win_x0_q      <= win_x0_d;
      win_y0_q      <= win_y0_d;
      win_w_q       <= win_w_d;
      win_h_q       <= win_h_d;
      decim_q       <= decim_d;
      data_q        <= data_d;
      dval_q        <= dval_d;
      xo_q          <= xo_d;
      yo_q          <= yo_d;
      frame_q       <= frame_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
    end
  end

  assign oDATA        = data_q;
  assign oDVAL        = dval_q;
  assign oX_Cont      = xo_q;
  assign oY_Cont      = yo_q;
  assign oFrame_Cont  = frame_q;
  assign oRUN         = run_q;
  assign oLINE_LEN    = line_len_q;
  assign oFRAME_LINES = frame_lines_q;
  assign oLEN_ERR     = err_q;

endmodule

// File: tb/tb_ccd_window_capture.sv
// Scoreboard bench for ccd_window_capture: directed frames push expected pixels,
// a negedge monitor pops and compares every oDVAL beat and queued status check.
module tb_ccd_window_capture;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned FRAME_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DATA_W-1:0]  data;
  logic               fval, lval, start, stop, decim, clr;
  logic [CNT_W-1:0]   win_x0, win_y0, win_w, win_h;
  logic [DATA_W-1:0]  oDATA;
  logic               oDVAL, oRUN, oLEN_ERR;
  logic [CNT_W-1:0]   oX_Cont, oY_Cont, oLINE_LEN, oFRAME_LINES;
  logic [FRAME_W-1:0] oFrame_Cont;

  always #5 clk = ~clk;

  ccd_window_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
    .iSTART(start), .iEND(stop), .iWIN_X0(win_x0), .iWIN_Y0(win_y0),
    .iWIN_W(win_w), .iWIN_H(win_h), .iDECIM(decim), .iCLR_ERR(clr),
    .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oFrame_Cont(oFrame_Cont), .oRUN(oRUN), .oLINE_LEN(oLINE_LEN),
    .oFRAME_LINES(oFRAME_LINES), .oLEN_ERR(oLEN_ERR)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [31:0]       cyc;
  } exp_t;

  typedef struct {
    string       nm;
    logic [63:0] a;
    logic [63:0] e;
  } chk_t;

  exp_t        q[$];
  chk_t        cq[$];
  exp_t        mon_e;
  chk_t        mon_c;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [31:0] cyc = 0;
  int          m_x0, m_y0, m_w, m_h;
  bit          m_dec;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: drain queued status checks, then score any presented pixel.
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      mon_c = cq.pop_front();
      n_cmp++;
      if (mon_c.a !== mon_c.e) begin
        n_err++;
        $display("FAIL %s: got %0d, required %0d", mon_c.nm, mon_c.a, mon_c.e);
      end
    end
    if (rst_n && oDVAL) begin
      n_out++;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_dval: got d=%0h x=%0d y=%0d at cyc %0d, required no output",
                 oDATA, oX_Cont, oY_Cont, cyc);
      end else begin
        mon_e = q.pop_front();
        if (oDATA !== mon_e.d || oX_Cont !== mon_e.x || oY_Cont !== mon_e.y || cyc !== mon_e.cyc) begin
          n_err++;
          $display("FAIL pixel: got d=%0h x=%0d y=%0d cyc=%0d, required d=%0h x=%0d y=%0d cyc=%0d",
                   oDATA, oX_Cont, oY_Cont, cyc, mon_e.d, mon_e.x, mon_e.y, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    chk_t c;
    c.nm = nm;
    c.a  = a;
    c.e  = e;
    cq.push_back(c);
  endtask

  function automatic bit mkeep(input int x, input int y);
    int dx = x - m_x0;
    int dy = y - m_y0;
    if (m_w == 0 || m_h == 0) return 1'b0;
    if (x < m_x0 || x >= m_x0 + m_w || y < m_y0 || y >= m_y0 + m_h) return 1'b0;
    if (m_dec && (((dx & 2) != 0) || ((dy & 2) != 0))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int mcomp(input int d);
    return m_dec ? (((d >> 2) << 1) | (d & 1)) : d;
  endfunction

  task automatic set_win(input int x0, input int y0, input int w, input int h, input bit dec);
    win_x0 = CNT_W'(x0); win_y0 = CNT_W'(y0); win_w = CNT_W'(w); win_h = CNT_W'(h);
    decim  = dec;
    m_x0 = x0; m_y0 = y0; m_w = w; m_h = h; m_dec = dec;
  endtask

  task automatic drive_px(input int x, input int y, input bit cap);
    exp_t e;
    @(negedge clk);
    lval = 1'b1;
    data = DATA_W'((y << 6) | x);
    if (cap && mkeep(x, y)) begin
      e.d   = DATA_W'((y << 6) | x);
      e.x   = CNT_W'(mcomp(x - m_x0));
      e.y   = CNT_W'(mcomp(y - m_y0));
      e.cyc = cyc + 32'd2;
      q.push_back(e);
    end
  endtask

  task automatic drive_line(input int y, input int npx, input bit cap, input bit pst, input bit pen);
    for (int x = 0; x < npx; x++) begin
      drive_px(x, y, cap);
      start = (x == 0) && pst;
      stop  = (x == 0) && pen;
    end
    @(negedge clk);
    lval = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_frame(input int nl, input int npx, input int short_y, input bit cap,
                             input int pst_y, input int pen_y, input int chg_y);
    logic [CNT_W-1:0] sx0;
    logic             sdec;
    sx0  = win_x0;
    sdec = decim;
    @(negedge clk);
    fval = 1'b1;
    repeat (2) @(negedge clk);
    for (int y = 0; y < nl; y++) begin
      if (y == chg_y) begin
        win_x0 = win_x0 + CNT_W'(1);
        decim  = ~decim;
      end
      drive_line(y, (y == short_y) ? npx - 1 : npx, cap, y == pst_y, y == pen_y);
    end
    fval = 1'b0;
    repeat (4) @(negedge clk);
    win_x0 = sx0;
    decim  = sdec;
  endtask

  task automatic arm();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_dval"}, 64'(oDVAL), 0);
    chk({p, "_data"}, 64'(oDATA), 0);
    chk({p, "_x"}, 64'(oX_Cont), 0);
    chk({p, "_y"}, 64'(oY_Cont), 0);
    chk({p, "_frame"}, 64'(oFrame_Cont), 0);
    chk({p, "_run"}, 64'(oRUN), 0);
    chk({p, "_linelen"}, 64'(oLINE_LEN), 0);
    chk({p, "_framelines"}, 64'(oFRAME_LINES), 0);
    chk({p, "_err"}, 64'(oLEN_ERR), 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; fval = 1'b0; lval = 1'b0;
    data = '0; clr = 1'b0;
    set_win(4, 2, 8, 4, 1'b0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Basic window 4,2,8x4
    arm();
    base = n_out;
    drive_frame(8, 16, -1, 1'b1, -1, -1, -1);
    chk("t1_count", 64'(n_out - base), 32);
    chk("t1_frames", 64'(oFrame_Cont), 1);
    chk("t1_linelen", 64'(oLINE_LEN), 16);
    chk("t1_framelines", 64'(oFRAME_LINES), 8);
    chk("t1_run", 64'(oRUN), 1);
    chk("t1_err", 64'(oLEN_ERR), 0);
    chk("t1_hold_x", 64'(oX_Cont), 7);
    chk("t1_hold_y", 64'(oY_Cont), 3);
    chk("t1_hold_data", 64'(oDATA), 331);
    chk("t1_queue", 64'(q.size()), 0);

    // Decimation over full frame, with mid-frame window/decim disturbance
    set_win(0, 0, 16, 8, 1'b1);
    base = n_out;
    drive_frame(8, 16, -1, 1'b1, -1, -1, 4);
    chk("t2_count", 64'(n_out - base), 32);
    chk("t2_frames", 64'(oFrame_Cont), 2);
    chk("t2_x", 64'(oX_Cont), 7);
    chk("t2_y", 64'(oY_Cont), 3);

    // Zero-width window: no output, frame still counted
    set_win(0, 0, 0, 8, 1'b0);
    base = n_out;
    drive_frame(8, 16, -1, 1'b1, -1, -1, -1);
    chk("t2w0_count", 64'(n_out - base), 0);
    chk("t2w0_frames", 64'(oFrame_Cont), 3);
    chk("t2w0_hold_x", 64'(oX_Cont), 7);
    chk("t2w0_framelines", 64'(oFRAME_LINES), 8);

    // Arm mid-frame: that frame skipped, next captured
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("t3_frames_rst", 64'(oFrame_Cont), 0);
    set_win(4, 2, 8, 4, 1'b0);
    base = n_out;
    drive_frame(8, 16, -1, 1'b0, 3, -1, -1);
    chk("t3_skip_count", 64'(n_out - base), 0);
    chk("t3_skip_frames", 64'(oFrame_Cont), 0);
    chk("t3_run", 64'(oRUN), 1);
    base = n_out;
    drive_frame(8, 16, -1, 1'b1, -1, -1, -1);
    chk("t3_count", 64'(n_out - base), 32);
    chk("t3_frames", 64'(oFrame_Cont), 1);

    // Stop+start together mid-frame: stop wins, frame completes
    base = n_out;
    drive_frame(8, 16, -1, 1'b1, 3, 3, -1);
    chk("t4_count", 64'(n_out - base), 32);
    chk("t4_frames", 64'(oFrame_Cont), 2);
    chk("t4_run", 64'(oRUN), 0);
    base = n_out;
    drive_frame(8, 16, -1, 1'b0, -1, -1, -1);
    chk("t4_idle_count", 64'(n_out - base), 0);
    chk("t4_idle_frames", 64'(oFrame_Cont), 2);

    // Short line 5 -> sticky length error, cleared by pulse
    set_win(0, 0, 16, 8, 1'b0);
    arm();
    base = n_out;
    drive_frame(8, 16, 4, 1'b1, -1, -1, -1);
    chk("t5_count", 64'(n_out - base), 127);
    chk("t5_err", 64'(oLEN_ERR), 1);
    chk("t5_frames", 64'(oFrame_Cont), 3);
    chk("t5_linelen", 64'(oLINE_LEN), 16);
    chk("t5_framelines", 64'(oFRAME_LINES), 8);
    base = n_out;
    drive_frame(8, 16, -1, 1'b1, -1, -1, -1);
    chk("t5_count2", 64'(n_out - base), 128);
    chk("t5_err_sticky", 64'(oLEN_ERR), 1);
    chk("t5_frames2", 64'(oFrame_Cont), 4);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    @(negedge clk);
    chk("t5_err_clr", 64'(oLEN_ERR), 0);

    // Asynchronous reset mid-line, then resume only on a fresh frame
    @(negedge clk) fval = 1'b1;
    repeat (2) @(negedge clk);
    drive_line(0, 16, 1'b1, 1'b0, 1'b0);
    for (int x = 0; x < 5; x++) drive_px(x, 1, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_zero("async");
    q.delete();
    lval = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_out;
    for (int y = 2; y < 8; y++) drive_line(y, 16, 1'b0, y == 3, 1'b0);
    fval = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_partial_count", 64'(n_out - base), 0);
    chk("t6_partial_frames", 64'(oFrame_Cont), 0);
    set_win(4, 2, 8, 4, 1'b0);
    base = n_out;
    drive_frame(8, 16, -1, 1'b1, -1, -1, -1);
    chk("t6_count", 64'(n_out - base), 32);
    chk("t6_frames", 64'(oFrame_Cont), 1);
    chk("t6_run", 64'(oRUN), 1);
    chk("t6_queue", 64'(q.size()), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ccd_window_capture.md
Name: ccd_window_capture

Overview:
- Parametrised successor to the D5M pixel capture stage: samples raw Bayer pixels with frame/line valid strobes on the pixel clock.
- Gates capture by start/stop control and crops to a programmable window. Optionally decimates 2x2 Bayer-preserving and emits window-relative coordinates.
- Also reports frame count and measured raw geometry (line length, lines per frame), with a sticky line-length error flag.
- Sits between the pixel input register and RAW2RGB/SDRAM write FIFOs.

Parameters:
- DATA_W, 12, pixel width.
- CNT_W, 16, width of X/Y counters and window registers.
- FRAME_W, 32, frame counter width.

Ports:
- iCLK  in  1  pixel clock.
- iRST_N  in  1  asynchronous active-low reset.
- iDATA  in  DATA_W  raw pixel.
- iFVAL  in  1  frame valid.
- iLVAL  in  1  line valid.
- iSTART  in  1  level/pulse: arm capture.
- iEND  in  1  level/pulse: disarm capture.
- iWIN_X0  in  CNT_W  window left column (raw coords).
- iWIN_Y0  in  CNT_W  window top row.
- iWIN_W  in  CNT_W  window width (raw pixels).
- iWIN_H  in  CNT_W  window height (raw lines).
- iDECIM  in  1  1 = 2x2 Bayer decimation.
- iCLR_ERR  in  1  clears oLEN_ERR.
- oDATA  out  DATA_W  captured pixel.
- oDVAL  out  1  oDATA valid.
- oX_Cont  out  CNT_W  window-relative output column.
- oY_Cont  out  CNT_W  window-relative output row.
- oFrame_Cont  out  FRAME_W  completed captured frames.
- oRUN  out  1  capture armed.
- oLINE_LEN  out  CNT_W  raw pixel count of last completed line.
- oFRAME_LINES  out  CNT_W  raw line count of last completed frame.
- oLEN_ERR  out  1  sticky line-length mismatch.

Behaviour:
- Reset: all outputs 0; run=0; state IDLE. Reset mid-frame aborts immediately; after release, wait for the next FVAL rise.
- Stage 1 registers iDATA/iFVAL/iLVAL (d1). Stage 2 registers outputs. A pixel present at edge k appears on oDATA/oDVAL at edge k+2.
- run: set by iSTART, cleared by iEND. If both are asserted, iEND wins. oRUN=run.
- FSM:
  - IDLE -> WAIT_FRAME when run=1.
  - WAIT_FRAME -> ACTIVE on FVAL_d1 rising edge if run=1. A frame already in progress at arm time is skipped.
  - WAIT_FRAME -> IDLE if run=0.
  - ACTIVE -> WAIT_FRAME on FVAL_d1 falling edge; oFrame_Cont increments (wraps) there. iEND during ACTIVE does not truncate the frame: the frame completes, then the FSM goes to IDLE.
- Window registers and iDECIM are shadowed at the ACTIVE entry edge. Changes mid-frame have no effect until the next frame.
- Raw x:
  - Counts FVAL_d1&LVAL_d1 cycles.
  - Zeroed on LVAL_d1 fall.
- Raw y:
  - Zeroed on FVAL_d1 rise.
  - Increments on each LVAL_d1 fall within the frame.
- Counters saturate at all-ones (no wrap).
- Pixel kept iff ACTIVE & LVAL_d1 & x>=X0 & x<X0+W & y>=Y0 & y<Y0+H, compared at CNT_W+1 bits so X0+W never overflows. With decim=1, also requires (x-X0)[1]==0 and (y-Y0)[1]==0.
- W=0 or H=0: no oDVAL for the frame; the frame still counts.
- oX_Cont/oY_Cont:
  - oX_Cont = (x-X0), right-shifted 1 with LSB = (x-X0)[0] when decim=1, giving a 2x2-block-compacted index that preserves Bayer parity.
  - oY_Cont is likewise derived from (y-Y0).
  - Both are held when oDVAL=0.
- oDATA is held when oDVAL=0.
- Geometry:
  - oLINE_LEN is updated with raw x at each LVAL_d1 fall during ACTIVE.
  - oFRAME_LINES is updated at FVAL_d1 fall.
  - Both hold until the next update.
- oLEN_ERR:
  - Sets when a completed line length differs from the previous line of the same frame. The first line of a frame is not compared.
  - Cleared by iCLR_ERR; set has priority over clear in the same cycle.

Test Plan:
- Arm, then 8 lines x 16 px with window X0=4,Y0=2,W=8,H=4, decim=0 -> 32 oDVAL pulses; oX_Cont 0..7, oY_Cont 0..3; first oDVAL 2 cycles after input pixel (4,2); oFrame_Cont=1, oLINE_LEN=16, oFRAME_LINES=8.
- Same frame with decim=1, window 0,0,16,8 -> 32 pixels kept; raw x {0,1,4,5,8,9,12,13} map to oX_Cont 0..7; rows 0,1,4,5 only.
- iSTART asserted mid-frame -> zero oDVAL that frame; next frame fully captured; oFrame_Cont=1.
- iEND at line 3 of 8, with iSTART asserted the same cycle -> frame completes with all windowed pixels; oRUN=0 afterwards; next frame produces no output.
- Line 5 of 8 is 15 px -> oLEN_ERR=1 and stays set across frames; iCLR_ERR pulse -> 0.
- iRST_N low mid-line -> all outputs 0 asynchronously; after release, capture resumes only on the next FVAL rise once armed.
